// File: rtl/capi_reset_seq_pkg.sv
// Shared types and widths for the CAPI reset sequencer.
package capi_reset_seq_pkg;

   localparam int CNT_W = 16;
   localparam int STG_W = 3;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      WAIT_ACK  = 2'd1,
      DONE      = 2'd2
   } seq_state_e;

endpackage

// File: rtl/capi_sync2.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module capi_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [1:0] sync_q;
   logic [1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[1];

endmodule

// File: rtl/capi_reset_sequencer.sv
// Ordered reset bring-up: qualifies PLL lock for a hold time, then releases
// per-domain resets one at a time, each gated by its ack or a timeout.
module capi_reset_sequencer
   import capi_reset_seq_pkg::*;
#(
   parameter int NUM_STAGES  = 4,
   parameter int HOLD_CYCLES = 1000,
   parameter int ACK_TIMEOUT = 4096
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  PLL_LOCKED,
   input  logic                  SOFT_RESET_REQ,
   input  logic [NUM_STAGES-1:0] STAGE_ACK,
   output logic [NUM_STAGES-1:0] STAGE_RESET,
   output logic [2:0]            CUR_STAGE,
   output logic                  ALL_RELEASED,
   output logic                  TIMEOUT_ERR
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [STG_W-1:0] LAST_STG  = STG_W'(NUM_STAGES - 1);

   logic                  lock_s;
   seq_state_e            state_q, state_d;
   logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
   logic [STG_W-1:0]      cur_stage_q, cur_stage_d;
   logic                  all_rel_q, all_rel_d;
   logic                  tmo_err_q, tmo_err_d;
   logic                  hold_done_q, hold_done_d;
   logic [CNT_W-1:0]      hold_cnt_q, hold_cnt_d;
   logic [CNT_W-1:0]      tmo_cnt_q, tmo_cnt_d;
   logic                  abort;
   logic                  ack_cur;
   logic                  accept;
   logic [STG_W-1:0]      nxt_stage;

   capi_sync2 u_lock_sync (
      .clk   (CLK),
      .rst_n (RESET_N),
      .d     (PLL_LOCKED),
      .q     (lock_s)
   );

   always_comb begin
      ack_cur = 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         if (cur_stage_q == STG_W'(i)) ack_cur = STAGE_ACK[i];
      end
   end

   always_comb begin
      state_d     = state_q;
      stage_rst_d = stage_rst_q;
      cur_stage_d = cur_stage_q;
      all_rel_d   = all_rel_q;
      tmo_err_d   = tmo_err_q;
      hold_done_d = hold_done_q;
      hold_cnt_d  = hold_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      abort       = !lock_s || SOFT_RESET_REQ;
      accept      = ack_cur || (tmo_cnt_q == TMO_LAST);
      nxt_stage   = cur_stage_q + STG_W'(1);

      // Abort outranks any accept; TIMEOUT_ERR survives until the next stage-0 release.
      if (state_q != WAIT_LOCK && abort) begin
         state_d     = WAIT_LOCK;
         stage_rst_d = '1;
         cur_stage_d = '0;
         all_rel_d   = 1'b0;
         hold_cnt_d  = '0;
         hold_done_d = 1'b0;
         tmo_cnt_d   = '0;
      end else begin
         case (state_q)
            WAIT_LOCK: begin
               if (abort) begin
                  hold_cnt_d  = '0;
                  hold_done_d = 1'b0;
               end else if (hold_done_q) begin
                  state_d        = WAIT_ACK;
                  stage_rst_d    = '1;
                  stage_rst_d[0] = 1'b0;
                  cur_stage_d    = '0;
                  tmo_cnt_d      = '0;
                  tmo_err_d      = 1'b0;
                  hold_cnt_d     = '0;
                  hold_done_d    = 1'b0;
               end else if (hold_cnt_q == HOLD_LAST) begin
                  hold_done_d = 1'b1;
               end else begin
                  hold_cnt_d = hold_cnt_q + CNT_W'(1);
               end
            end
            WAIT_ACK: begin
               if (accept) begin
                  if (!ack_cur) tmo_err_d = 1'b1;
                  if (cur_stage_q == LAST_STG) begin
                     state_d   = DONE;
                     all_rel_d = 1'b1;
                  end else begin
                     for (int i = 0; i < NUM_STAGES; i++) begin
                        if (nxt_stage == STG_W'(i)) stage_rst_d[i] = 1'b0;
                     end
                     cur_stage_d = nxt_stage;
                     tmo_cnt_d   = '0;
                  end
               end else begin
                  tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
            end
            default: begin
               state_d     = WAIT_LOCK;
               stage_rst_d = '1;
               cur_stage_d = '0;
               all_rel_d   = 1'b0;
               hold_cnt_d  = '0;
               hold_done_d = 1'b0;
               tmo_cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= WAIT_LOCK;
         stage_rst_q <= '1;
         cur_stage_q <= '0;
         all_rel_q   <= 1'b0;
         tmo_err_q   <= 1'b0;
         hold_done_q <= 1'b0;
         hold_cnt_q  <= '0;
         tmo_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         stage_rst_q <= stage_rst_d;
         cur_stage_q <= cur_stage_d;
         all_rel_q   <= all_rel_d;
         tmo_err_q   <= tmo_err_d;
         hold_done_q <= hold_done_d;
         hold_cnt_q  <= hold_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
      end
   end

   assign STAGE_RESET  = stage_rst_q;
   assign CUR_STAGE    = cur_stage_q;
   assign ALL_RELEASED = all_rel_q;
   assign TIMEOUT_ERR  = tmo_err_q;

endmodule

// File: tb/tb_capi_reset_sequencer.sv
// Directed bench for capi_reset_sequencer with NUM_STAGES=3, HOLD_CYCLES=8, ACK_TIMEOUT=16.
module tb_capi_reset_sequencer;

   localparam int NS = 3;
   localparam int HC = 8;
   localparam int AT = 16;

   logic          CLK = 1'b0;
   logic          RESET_N;
   logic          PLL_LOCKED;
   logic          SOFT_RESET_REQ;
   logic [NS-1:0] STAGE_ACK;
   logic [NS-1:0] STAGE_RESET;
   logic [2:0]    CUR_STAGE;
   logic          ALL_RELEASED;
   logic          TIMEOUT_ERR;

   int checks = 0;
   int errors = 0;

   capi_reset_sequencer #(
      .NUM_STAGES  (NS),
      .HOLD_CYCLES (HC),
      .ACK_TIMEOUT (AT)
   ) dut (
      .CLK            (CLK),
      .RESET_N        (RESET_N),
      .PLL_LOCKED     (PLL_LOCKED),
      .SOFT_RESET_REQ (SOFT_RESET_REQ),
      .STAGE_ACK      (STAGE_ACK),
      .STAGE_RESET    (STAGE_RESET),
      .CUR_STAGE      (CUR_STAGE),
      .ALL_RELEASED   (ALL_RELEASED),
      .TIMEOUT_ERR    (TIMEOUT_ERR)
   );

   always #5 CLK = ~CLK;

   // Advance n rising edges and land 1ns after the last one.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic do_reset;
      RESET_N        = 1'b0;
      PLL_LOCKED     = 1'b0;
      SOFT_RESET_REQ = 1'b0;
      STAGE_ACK      = '0;
      step(2);
      RESET_N = 1'b1;
      step(1);
   endtask

   task automatic test_reset;
      RESET_N        = 1'b0;
      PLL_LOCKED     = 1'b0;
      SOFT_RESET_REQ = 1'b0;
      STAGE_ACK      = '0;
      step(2);
      checks++;
      if (STAGE_RESET !== 3'b111) begin errors++; $display("FAIL reset_stage_reset: got %b want 111", STAGE_RESET); end
      checks++;
      if (CUR_STAGE !== 3'd0) begin errors++; $display("FAIL reset_cur_stage: got %0d want 0", CUR_STAGE); end
      checks++;
      if (ALL_RELEASED !== 1'b0) begin errors++; $display("FAIL reset_all_released: got %b want 0", ALL_RELEASED); end
      checks++;
      if (TIMEOUT_ERR !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", TIMEOUT_ERR); end
      RESET_N   = 1'b1;
      STAGE_ACK = '1;
      step(20);
      checks++;
      if (STAGE_RESET !== 3'b111) begin errors++; $display("FAIL nolock_hold: got %b want 111", STAGE_RESET); end
   endtask

   task automatic test_basic;
      logic [2:0] exp_rst [0:4] = '{3'b111, 3'b110, 3'b100, 3'b000, 3'b000};
      logic [2:0] exp_cur [0:4] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd2};
      logic       exp_all [0:4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      STAGE_ACK  = '1;
      PLL_LOCKED = 1'b1;
      step(10);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (STAGE_RESET !== exp_rst[k]) begin errors++; $display("FAIL basic_rst_e%0d: got %b want %b", 10 + k, STAGE_RESET, exp_rst[k]); end
         checks++;
         if (CUR_STAGE !== exp_cur[k]) begin errors++; $display("FAIL basic_cur_e%0d: got %0d want %0d", 10 + k, CUR_STAGE, exp_cur[k]); end
         checks++;
         if (ALL_RELEASED !== exp_all[k]) begin errors++; $display("FAIL basic_all_e%0d: got %b want %b", 10 + k, ALL_RELEASED, exp_all[k]); end
         if (k < 4) step(1);
      end
      checks++;
      if (TIMEOUT_ERR !== 1'b0) begin errors++; $display("FAIL basic_terr: got %b want 0", TIMEOUT_ERR); end
      STAGE_ACK = '0;
      step(3);
      checks++;
      if (ALL_RELEASED !== 1'b1 || STAGE_RESET !== 3'b000) begin
         errors++; $display("FAIL done_hold: got all=%b rst=%b want all=1 rst=000", ALL_RELEASED, STAGE_RESET);
      end
   endtask

   task automatic test_glitch;
      do_reset();
      STAGE_ACK  = '1;
      PLL_LOCKED = 1'b1;
      step(5);
      PLL_LOCKED = 1'b0;
      step(1);
      PLL_LOCKED = 1'b1;
      step(10);
      checks++;
      if (STAGE_RESET !== 3'b111) begin errors++; $display("FAIL glitch_early: got %b want 111", STAGE_RESET); end
      step(1);
      checks++;
      if (STAGE_RESET !== 3'b110) begin errors++; $display("FAIL glitch_release: got %b want 110", STAGE_RESET); end
   endtask

   task automatic test_timeout;
      do_reset();
      STAGE_ACK  = 3'b101;
      PLL_LOCKED = 1'b1;
      step(12);
      checks++;
      if (STAGE_RESET !== 3'b100 || CUR_STAGE !== 3'd1) begin
         errors++; $display("FAIL tmo_stage1: got rst=%b cur=%0d want rst=100 cur=1", STAGE_RESET, CUR_STAGE);
      end
      step(15);
      checks++;
      if (STAGE_RESET !== 3'b100 || TIMEOUT_ERR !== 1'b0) begin
         errors++; $display("FAIL tmo_early: got rst=%b terr=%b want rst=100 terr=0", STAGE_RESET, TIMEOUT_ERR);
      end
      step(1);
      checks++;
      if (STAGE_RESET !== 3'b000 || TIMEOUT_ERR !== 1'b1 || CUR_STAGE !== 3'd2) begin
         errors++; $display("FAIL tmo_fire: got rst=%b terr=%b cur=%0d want rst=000 terr=1 cur=2", STAGE_RESET, TIMEOUT_ERR, CUR_STAGE);
      end
      step(1);
      checks++;
      if (ALL_RELEASED !== 1'b1 || TIMEOUT_ERR !== 1'b1) begin
         errors++; $display("FAIL tmo_done: got all=%b terr=%b want all=1 terr=1", ALL_RELEASED, TIMEOUT_ERR);
      end
      step(5);
      checks++;
      if (TIMEOUT_ERR !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", TIMEOUT_ERR); end
   endtask

   // Starts from DONE with TIMEOUT_ERR set, left by test_timeout.
   task automatic test_lock_loss;
      STAGE_ACK  = 3'b001;
      PLL_LOCKED = 1'b0;
      step(2);
      checks++;
      if (STAGE_RESET !== 3'b000 || ALL_RELEASED !== 1'b1) begin
         errors++; $display("FAIL loss_done_early: got rst=%b all=%b want rst=000 all=1", STAGE_RESET, ALL_RELEASED);
      end
      step(1);
      checks++;
      if (STAGE_RESET !== 3'b111 || ALL_RELEASED !== 1'b0 || CUR_STAGE !== 3'd0) begin
         errors++; $display("FAIL loss_done_abort: got rst=%b all=%b cur=%0d want rst=111 all=0 cur=0", STAGE_RESET, ALL_RELEASED, CUR_STAGE);
      end
      checks++;
      if (TIMEOUT_ERR !== 1'b1) begin errors++; $display("FAIL loss_terr_kept: got %b want 1", TIMEOUT_ERR); end
      PLL_LOCKED = 1'b1;
      step(11);
      checks++;
      if (STAGE_RESET !== 3'b110 || TIMEOUT_ERR !== 1'b0) begin
         errors++; $display("FAIL relock_rel0: got rst=%b terr=%b want rst=110 terr=0", STAGE_RESET, TIMEOUT_ERR);
      end
      step(1);
      checks++;
      if (STAGE_RESET !== 3'b100 || CUR_STAGE !== 3'd1) begin
         errors++; $display("FAIL relock_stage1: got rst=%b cur=%0d want rst=100 cur=1", STAGE_RESET, CUR_STAGE);
      end
      step(2);
      PLL_LOCKED = 1'b0;
      step(2);
      checks++;
      if (STAGE_RESET !== 3'b100) begin errors++; $display("FAIL loss_ack_early: got %b want 100", STAGE_RESET); end
      step(1);
      checks++;
      if (STAGE_RESET !== 3'b111 || CUR_STAGE !== 3'd0 || ALL_RELEASED !== 1'b0) begin
         errors++; $display("FAIL loss_ack_abort: got rst=%b cur=%0d all=%b want rst=111 cur=0 all=0", STAGE_RESET, CUR_STAGE, ALL_RELEASED);
      end
      STAGE_ACK  = '1;
      PLL_LOCKED = 1'b1;
      step(11);
      checks++;
      if (STAGE_RESET !== 3'b110) begin errors++; $display("FAIL reseq_rel0: got %b want 110", STAGE_RESET); end
      step(2);
      checks++;
      if (STAGE_RESET !== 3'b000) begin errors++; $display("FAIL reseq_rel2: got %b want 000", STAGE_RESET); end
      step(1);
      checks++;
      if (ALL_RELEASED !== 1'b1 || TIMEOUT_ERR !== 1'b0) begin
         errors++; $display("FAIL reseq_done: got all=%b terr=%b want all=1 terr=0", ALL_RELEASED, TIMEOUT_ERR);
      end
   endtask

   task automatic test_collision;
      do_reset();
      STAGE_ACK  = 3'b011;
      PLL_LOCKED = 1'b1;
      step(13);
      checks++;
      if (STAGE_RESET !== 3'b000 || CUR_STAGE !== 3'd2) begin
         errors++; $display("FAIL coll_stage2: got rst=%b cur=%0d want rst=000 cur=2", STAGE_RESET, CUR_STAGE);
      end
      step(2);
      STAGE_ACK      = 3'b111;
      SOFT_RESET_REQ = 1'b1;
      step(1);
      SOFT_RESET_REQ = 1'b0;
      checks++;
      if (STAGE_RESET !== 3'b111 || ALL_RELEASED !== 1'b0 || CUR_STAGE !== 3'd0) begin
         errors++; $display("FAIL coll_abort: got rst=%b all=%b cur=%0d want rst=111 all=0 cur=0", STAGE_RESET, ALL_RELEASED, CUR_STAGE);
      end
      for (int e = 17; e <= 24; e++) begin
         step(1);
         checks++;
         if (STAGE_RESET !== 3'b111 || ALL_RELEASED !== 1'b0) begin
            errors++; $display("FAIL coll_hold_e%0d: got rst=%b all=%b want rst=111 all=0", e, STAGE_RESET, ALL_RELEASED);
         end
      end
      step(1);
      checks++;
      if (STAGE_RESET !== 3'b110) begin errors++; $display("FAIL coll_reseq: got %b want 110", STAGE_RESET); end
      step(3);
      checks++;
      if (ALL_RELEASED !== 1'b1) begin errors++; $display("FAIL coll_done: got %b want 1", ALL_RELEASED); end
      SOFT_RESET_REQ = 1'b1;
      step(1);
      SOFT_RESET_REQ = 1'b0;
      checks++;
      if (STAGE_RESET !== 3'b111 || ALL_RELEASED !== 1'b0) begin
         errors++; $display("FAIL soft_done: got rst=%b all=%b want rst=111 all=0", STAGE_RESET, ALL_RELEASED);
      end
   endtask

   task automatic test_async_reset;
      do_reset();
      STAGE_ACK  = 3'b101;
      PLL_LOCKED = 1'b1;
      step(29);
      checks++;
      if (ALL_RELEASED !== 1'b1 || TIMEOUT_ERR !== 1'b1 || CUR_STAGE !== 3'd2) begin
         errors++; $display("FAIL async_pre: got all=%b terr=%b cur=%0d want all=1 terr=1 cur=2", ALL_RELEASED, TIMEOUT_ERR, CUR_STAGE);
      end
      #2;
      RESET_N = 1'b0;
      #1;
      checks++;
      if (STAGE_RESET !== 3'b111) begin errors++; $display("FAIL async_rst: got %b want 111", STAGE_RESET); end
      checks++;
      if (CUR_STAGE !== 3'd0 || ALL_RELEASED !== 1'b0 || TIMEOUT_ERR !== 1'b0) begin
         errors++; $display("FAIL async_outs: got cur=%0d all=%b terr=%b want cur=0 all=0 terr=0", CUR_STAGE, ALL_RELEASED, TIMEOUT_ERR);
      end
      RESET_N = 1'b1;
      step(1);
   endtask

   initial begin
      RESET_N        = 1'b0;
      PLL_LOCKED     = 1'b0;
      SOFT_RESET_REQ = 1'b0;
      STAGE_ACK      = '0;
      test_reset();
      test_basic();
      test_glitch();
      test_timeout();
      test_lock_loss();
      test_collision();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
